sipo_frame_aligner: RTL

- Downstream consumer of the serial-to-parallel stage. Its 8-bit window input updates once per clock, with one new serial bit at bit 0.
- Hunts for a sync byte in the sliding window and locks byte alignment. Parses frames of the form SYNC, LEN, then LEN payload bytes.
- Emits aligned payload bytes with valid, start-of-frame and end-of-frame strobes to the packet layer.
- Tolerates a bounded number of missed sync slots before dropping lock.

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_bit_counter.sv | 38 +++
 rtl/sipo_frame_aligner.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO frame aligner.
//   BYTE_W         : width of the parallel window and payload bytes
//   SYNC_BYTE_DFLT : default frame delimiter pattern
//   state_t        : aligner state machine encoding
package sipo_pkg;

    localparam int unsigned       BYTE_W         = 8;
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DFLT = 8'hA5;

    typedef enum logic [1:0] {
        HUNT,
        GET_LEN,
        PAYLOAD,
        CHECK_SYNC
    } state_t;

endpackage

// File: rtl/sipo_bit_counter.sv
// 3-bit byte-boundary counter for the frame aligner.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : clear counter to 0 (takes priority over en_i)
//   en_i        : count one bit per clock
//   boundary_o  : high while enabled and the counter is at 7, i.e. the
//                 current edge completes a byte and wraps the count
module sipo_bit_counter (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic boundary_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign boundary_o = en_i && (cnt_q == 3'd7);

endmodule

// File: rtl/sipo_frame_aligner.sv
// Byte aligner and frame parser behind a serial-to-parallel stage.
// Hunts for SYNC_BYTE in the sliding window, then parses SYNC, LEN, payload
// frames on 8-clock boundaries and emits payload bytes with strobes.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   p_i[7:0]      : sliding window, newest serial bit in p_i[0]
//   byte_o[7:0]   : aligned payload byte (holds when not valid)
//   byte_valid_o  : one-cycle strobe qualifying byte_o
//   sof_o, eof_o  : first / last payload byte of a frame
//   locked_o      : high in every state except HUNT
//   sync_err_o    : one-cycle pulse on each bad sync slot
module sipo_frame_aligner
    import sipo_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DFLT,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] p_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       sof_o,
    output logic       eof_o,
    output logic       locked_o,
    output logic       sync_err_o
);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [2:0] miss_q, miss_d;
    logic       first_q, first_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic       sof_q, sof_d;
    logic       eof_q, eof_d;
    logic       err_q, err_d;

    logic       bit_clr;
    logic       bit_en;
    logic       boundary;

    assign bit_en = (state_q != HUNT);

    sipo_bit_counter u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (bit_clr),
        .en_i       (bit_en),
        .boundary_o (boundary)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        miss_d  = miss_q;
        first_d = first_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        bit_clr = 1'b0;

        unique case (state_q)
            HUNT: begin
                // Window is checked every clock, so any bit alignment locks.
                if (p_i == SYNC_BYTE) begin
                    state_d = GET_LEN;
                    bit_clr = 1'b1;
                    miss_d  = '0;
                end
            end
            GET_LEN: begin
                if (boundary) begin
                    len_d = p_i;
                    if (p_i == 8'h00) begin
                        state_d = CHECK_SYNC;
                    end else begin
                        state_d = PAYLOAD;
                        first_d = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (boundary) begin
                    byte_d  = p_i;
                    valid_d = 1'b1;
                    sof_d   = first_q;
                    first_d = 1'b0;
                    eof_d   = (len_q == 8'd1);
                    len_d   = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        state_d = CHECK_SYNC;
                    end
                end
            end
            CHECK_SYNC: begin
                if (boundary) begin
                    if (p_i == SYNC_BYTE) begin
                        miss_d  = '0;
                        state_d = GET_LEN;
                    end else begin
                        err_d = 1'b1;
                        if (miss_q == 3'(MISS_LIMIT)) begin
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_q + 3'd1;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            len_q   <= '0;
            miss_q  <= '0;
            first_q <= 1'b0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            miss_q  <= miss_d;
            first_q <= first_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign sof_o        = sof_q;
    assign eof_o        = eof_q;
    assign sync_err_o   = err_q;
    assign locked_o     = (state_q != HUNT);

endmodule
